// File: rtl/univ_reg.sv
// univ_reg: WIDTH-bit universal register cell.
// Modes: hold / load / shift-left / shift-right / increment / decrement / clear.
// Optional build macro UNIV_REG_SAT_EN: INC at all-ones and DEC at zero
// saturate (q holds) instead of wrapping. tc behaves the same in both builds.
module univ_reg #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q,
  output logic             ser_out,
  output logic             zero,
  output logic             tc
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_SHL  = 3'b010,
    OP_SHR  = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } op_e;

  op_e              op_s;
  logic             all_ones;
  logic             is_zero;
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;

  assign op_s     = op_e'(op);
  assign all_ones = &q;
  assign is_zero  = ~|q;

  // Shift results; a 1-bit cell simply takes the serial input in either direction.
  generate
    if (WIDTH == 1) begin : g_w1
      assign shl_val = ser_in;
      assign shr_val = ser_in;
    end else begin : g_wn
      assign shl_val = {q[WIDTH-2:0], ser_in};
      assign shr_val = {ser_in, q[WIDTH-1:1]};
    end
  endgenerate

  // Next-state selection for q and ser_out; en=0 or HOLD/reserved keeps both.
  always_comb begin
    q_nxt  = q;
    so_nxt = ser_out;
    if (en) begin
      case (op_s)
        OP_LOAD: q_nxt = d;
        OP_SHL: begin
          q_nxt  = shl_val;
          so_nxt = q[WIDTH-1];
        end
        OP_SHR: begin
          q_nxt  = shr_val;
          so_nxt = q[0];
        end
        OP_INC: begin
`ifdef UNIV_REG_SAT_EN
          if (!all_ones) q_nxt = q + WIDTH'(1);
`else
          q_nxt = q + WIDTH'(1);
`endif
        end
        OP_DEC: begin
`ifdef UNIV_REG_SAT_EN
          if (!is_zero) q_nxt = q - WIDTH'(1);
`else
          q_nxt = q - WIDTH'(1);
`endif
        end
        OP_CLR:  q_nxt = '0;
        default: ;
      endcase
    end
  end

  // State register; reset wins over any operation presented in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q       <= RESET_VAL;
      ser_out <= 1'b0;
    end else begin
      q       <= q_nxt;
      ser_out <= so_nxt;
    end
  end

  // Status: zero tracks q; tc flags the cycle before a wrap so the next cell can ripple.
  assign zero = is_zero;
  assign tc   = en & (((op_s == OP_INC) & all_ones) | ((op_s == OP_DEC) & is_zero));

endmodule

// File: tb/tb_univ_reg.sv
// tb_univ_reg: randomized and directed checks of univ_reg against an
// arithmetic reference model (values held as plain integers mod 256).
module tb_univ_reg;

  logic       clk = 1'b0;
  logic       reset_n;
  // main 8-bit cell
  logic       en;
  logic [2:0] op;
  logic [7:0] d;
  logic       si;
  logic [7:0] q;
  logic       so, zero, tc;
  // cascaded pair
  logic       c_en_lo, c_en_hi_drv, c_use_tc, c_si;
  logic [2:0] c_op;
  logic [7:0] c_d_lo, c_d_hi, c_q_lo, c_q_hi;
  logic       c_so_lo, c_so_hi, c_z_lo, c_z_hi, c_tc_lo, c_tc_hi, c_en_hi;
  // 1-bit cell
  logic       w_en, w_d, w_si, w_q, w_so, w_z, w_tc;
  logic [2:0] w_op;

  int passed = 0;
  int total  = 0;
  int m_q, m_so;

  always #5 clk = ~clk;

  univ_reg #(.WIDTH(8), .RESET_VAL(8'h5A)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .op(op), .d(d), .ser_in(si),
    .q(q), .ser_out(so), .zero(zero), .tc(tc));

  assign c_en_hi = c_use_tc ? c_tc_lo : c_en_hi_drv;

  univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) c_lo (
    .clk(clk), .reset_n(reset_n), .en(c_en_lo), .op(c_op), .d(c_d_lo), .ser_in(c_si),
    .q(c_q_lo), .ser_out(c_so_lo), .zero(c_z_lo), .tc(c_tc_lo));

  univ_reg #(.WIDTH(8), .RESET_VAL(8'h00)) c_hi (
    .clk(clk), .reset_n(reset_n), .en(c_en_hi), .op(c_op), .d(c_d_hi), .ser_in(c_si),
    .q(c_q_hi), .ser_out(c_so_hi), .zero(c_z_hi), .tc(c_tc_hi));

  univ_reg #(.WIDTH(1), .RESET_VAL(1'b0)) w1 (
    .clk(clk), .reset_n(reset_n), .en(w_en), .op(w_op), .d(w_d), .ser_in(w_si),
    .q(w_q), .ser_out(w_so), .zero(w_z), .tc(w_tc));

  // drive main-cell inputs and let combinational outputs settle
  task automatic drive(input logic e, input logic [2:0] o, input logic [7:0] dd, input logic s);
    en = e; op = o; d = dd; si = s;
    #1;
  endtask

  // one rising edge, then step away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: what the register holds after one accepted cycle
  task automatic model_step(input logic e, input logic [2:0] o, input logic [7:0] dd, input logic s);
    if (!e) return;
    case (o)
      3'd1: m_q = int'(dd);
      3'd2: begin m_so = m_q / 128; m_q = (m_q * 2) % 256 + int'(s); end
      3'd3: begin m_so = m_q % 2;   m_q = m_q / 2 + int'(s) * 128; end
      3'd4: begin
`ifdef UNIV_REG_SAT_EN
        if (m_q != 255)
`endif
          m_q = (m_q + 1) % 256;
      end
      3'd5: begin
`ifdef UNIV_REG_SAT_EN
        if (m_q != 0)
`endif
          m_q = (m_q + 255) % 256;
      end
      3'd6: m_q = 0;
      default: ;
    endcase
  endtask

  function automatic logic model_tc(input logic e, input logic [2:0] o);
    return e && ((o == 3'd4 && m_q == 255) || (o == 3'd5 && m_q == 0));
  endfunction

  // cycle of the main cell with the model advanced alongside
  task automatic run(input logic e, input logic [2:0] o, input logic [7:0] dd, input logic s);
    drive(e, o, dd, s);
    tick();
    model_step(e, o, dd, s);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 3'd4, 8'h00, 1'b1);
    c_en_lo = 1'b0; c_en_hi_drv = 1'b0; c_use_tc = 1'b0; c_op = 3'd0;
    c_d_lo = 8'h00; c_d_hi = 8'h00; c_si = 1'b0;
    w_en = 1'b0; w_op = 3'd0; w_d = 1'b0; w_si = 1'b0;
    tick();
    tick();
    m_q = 'h5A; m_so = 0;
    total++; if (q !== 8'h5A) begin $display("FAIL reset_q: got %h want 5a", q); end else passed++;
    total++; if (so !== 1'b0) begin $display("FAIL reset_ser_out: got %b want 0", so); end else passed++;
    total++; if (zero !== 1'b0) begin $display("FAIL reset_zero: got %b want 0", zero); end else passed++;
    total++; if ({c_q_hi, c_q_lo, w_q} !== 17'h0) begin $display("FAIL reset_aux: got %h want 0", {c_q_hi, c_q_lo, w_q}); end else passed++;
    reset_n = 1'b1;
  endtask

  task automatic test_inc_wrap();
    run(1'b1, 3'd1, 8'hFE, 1'b0);
    total++; if (q !== 8'hFE) begin $display("FAIL inc_load: got %h want fe", q); end else passed++;
    drive(1'b1, 3'd4, 8'h00, 1'b0);
    total++; if (tc !== 1'b0) begin $display("FAIL inc_tc_fe: got %b want 0", tc); end else passed++;
    run(1'b1, 3'd4, 8'h00, 1'b0);
    total++; if (q !== 8'hFF) begin $display("FAIL inc_ff: got %h want ff", q); end else passed++;
    drive(1'b1, 3'd4, 8'h00, 1'b0);
    total++; if (tc !== 1'b1) begin $display("FAIL inc_tc_ff: got %b want 1", tc); end else passed++;
    drive(1'b1, 3'd5, 8'h00, 1'b0);
    total++; if (tc !== 1'b0) begin $display("FAIL inc_tc_dec_at_ff: got %b want 0", tc); end else passed++;
    run(1'b1, 3'd4, 8'h00, 1'b0);
`ifdef UNIV_REG_SAT_EN
    total++; if (q !== 8'hFF || zero !== 1'b0) begin $display("FAIL inc_sat: got %h/%b want ff/0", q, zero); end else passed++;
`else
    total++; if (q !== 8'h00 || zero !== 1'b1) begin $display("FAIL inc_wrap: got %h/%b want 00/1", q, zero); end else passed++;
`endif
  endtask

  task automatic test_shift();
    run(1'b1, 3'd1, 8'h81, 1'b0);
    run(1'b1, 3'd2, 8'h00, 1'b0);
    total++; if (q !== 8'h02 || so !== 1'b1) begin $display("FAIL shl: got %h/%b want 02/1", q, so); end else passed++;
    run(1'b1, 3'd3, 8'h00, 1'b1);
    total++; if (q !== 8'h81 || so !== 1'b0) begin $display("FAIL shr: got %h/%b want 81/0", q, so); end else passed++;
    run(1'b1, 3'd3, 8'h00, 1'b0);
    run(1'b1, 3'd1, 8'h00, 1'b0);
    total++; if (so !== 1'b1) begin $display("FAIL so_hold_on_load: got %b want 1", so); end else passed++;
  endtask

  task automatic test_dec();
    run(1'b1, 3'd1, 8'h01, 1'b0);
    drive(1'b1, 3'd5, 8'h00, 1'b0);
    total++; if (tc !== 1'b0) begin $display("FAIL dec_tc_01: got %b want 0", tc); end else passed++;
    run(1'b1, 3'd5, 8'h00, 1'b0);
    total++; if (q !== 8'h00 || zero !== 1'b1) begin $display("FAIL dec_00: got %h/%b want 00/1", q, zero); end else passed++;
    drive(1'b1, 3'd5, 8'h00, 1'b0);
    total++; if (tc !== 1'b1) begin $display("FAIL dec_tc_00: got %b want 1", tc); end else passed++;
    drive(1'b0, 3'd5, 8'h00, 1'b0);
    total++; if (tc !== 1'b0) begin $display("FAIL dec_tc_en0: got %b want 0", tc); end else passed++;
    run(1'b1, 3'd5, 8'h00, 1'b0);
`ifdef UNIV_REG_SAT_EN
    total++; if (q !== 8'h00) begin $display("FAIL dec_sat: got %h want 00", q); end else passed++;
`else
    total++; if (q !== 8'hFF) begin $display("FAIL dec_wrap: got %h want ff", q); end else passed++;
`endif
  endtask

  task automatic test_hold_clr();
    run(1'b1, 3'd1, 8'hC3, 1'b0);
    run(1'b1, 3'd3, 8'h00, 1'b0);  // q=61, ser_out=1
    for (int i = 0; i < 3; i++) run(1'b0, 3'd1, 8'h33, 1'b1);
    total++; if (q !== 8'h61 || so !== 1'b1) begin $display("FAIL hold_en0: got %h/%b want 61/1", q, so); end else passed++;
    run(1'b1, 3'd7, 8'h33, 1'b0);
    total++; if (q !== 8'h61 || so !== 1'b1) begin $display("FAIL hold_rsvd: got %h/%b want 61/1", q, so); end else passed++;
    run(1'b1, 3'd6, 8'h33, 1'b0);
    total++; if (q !== 8'h00 || zero !== 1'b1) begin $display("FAIL clr: got %h/%b want 00/1", q, zero); end else passed++;
  endtask

  task automatic test_cascade();
    c_use_tc = 1'b0; c_en_lo = 1'b1; c_en_hi_drv = 1'b1;
    c_op = 3'd1; c_d_lo = 8'hFF; c_d_hi = 8'h00;
    tick();
    c_use_tc = 1'b1; c_op = 3'd4;
    #1;
    total++; if (c_tc_lo !== 1'b1) begin $display("FAIL casc_tc: got %b want 1", c_tc_lo); end else passed++;
    tick();
`ifdef UNIV_REG_SAT_EN
    total++; if ({c_q_hi, c_q_lo} !== 16'h01FF) begin $display("FAIL casc_inc: got %h want 01ff", {c_q_hi, c_q_lo}); end else passed++;
`else
    total++; if ({c_q_hi, c_q_lo} !== 16'h0100) begin $display("FAIL casc_inc: got %h want 0100", {c_q_hi, c_q_lo}); end else passed++;
    tick();
    total++; if ({c_q_hi, c_q_lo} !== 16'h0101) begin $display("FAIL casc_inc2: got %h want 0101", {c_q_hi, c_q_lo}); end else passed++;
`endif
    c_en_lo = 1'b0; c_use_tc = 1'b0; c_en_hi_drv = 1'b0;
  endtask

  task automatic test_width1();
    w_en = 1'b1; w_op = 3'd2; w_si = 1'b1;
    tick();
    total++; if (w_q !== 1'b1 || w_so !== 1'b0) begin $display("FAIL w1_shl: got %b/%b want 1/0", w_q, w_so); end else passed++;
    w_op = 3'd3; w_si = 1'b0;
    tick();
    total++; if (w_q !== 1'b0 || w_so !== 1'b1) begin $display("FAIL w1_shr: got %b/%b want 0/1", w_q, w_so); end else passed++;
    w_op = 3'd5;
    #1;
    total++; if (w_tc !== 1'b1) begin $display("FAIL w1_tc: got %b want 1", w_tc); end else passed++;
    w_en = 1'b0;
  endtask

  // back-to-back random ops every cycle, with occasional reset
  task automatic test_random();
    logic       e, s, r;
    logic [2:0] o;
    logic [7:0] dd;
    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(0, 7) != 0);
      o  = 3'($urandom_range(0, 7));
      dd = 8'($urandom);
      s  = 1'($urandom);
      r  = ($urandom_range(0, 39) == 0);
      if (($urandom_range(0, 3) == 0)) dd = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      drive(e, o, dd, s);
      total++;
      if (tc !== model_tc(e, o) || zero !== (m_q == 0)) begin
        $display("FAIL rand_flags[%0d]: got tc=%b zero=%b want tc=%b zero=%b", i, tc, zero, model_tc(e, o), (m_q == 0));
      end else passed++;
      reset_n = !r;
      tick();
      if (r) begin m_q = 'h5A; m_so = 0; end
      else model_step(e, o, dd, s);
      reset_n = 1'b1;
      total++;
      if (q !== 8'(m_q) || so !== 1'(m_so)) begin
        $display("FAIL rand_state[%0d]: got q=%h so=%b want q=%h so=%0d", i, q, so, 8'(m_q), m_so);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_shift();
    test_dec();
    test_hold_clr();
    test_cascade();
    test_width1();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
